// File: rtl/dmem_lsu.sv
// Load/store unit between the RV32I memory stage and a word-wide data memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module dmem_lsu #(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_write,
  output logic        dmem_read,
  input  logic [31:0] dmem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: cpu_req is sampled only while cpu_busy=0 (IDLE); the core keeps the
  // request stable until it sees the single-cycle cpu_done, which carries cpu_err/cpu_rdata.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(DMEM_WORDS);

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        req_err;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [15:0] wd, input logic [31:0] word);
    logic [31:0] r;
    r = word;
    if (f3[1:0] == 2'b00) r[8*lane +: 8] = wd[7:0];
    else                  r[16*lane[1] +: 16] = wd;
    return r;
  endfunction

  // Any of these rejects the access before dmem is touched.
  always_comb begin
    req_err = 1'b0;
    if (cpu_funct3 == 3'b011 || cpu_funct3 == 3'b110 || cpu_funct3 == 3'b111) req_err = 1'b1;
    if (cpu_we && cpu_funct3[2])                                            req_err = 1'b1;
    if (cpu_funct3[1:0] == 2'b01 && cpu_addr[0])                            req_err = 1'b1;
    if (cpu_funct3 == 3'b010 && cpu_addr[1:0] != 2'b00)                     req_err = 1'b1;
    if (cpu_addr[31:2] >= WORD_LIMIT)                                       req_err = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (req_err)                              state_nxt = DONE;
          else if (cpu_we && cpu_funct3 == 3'b010)  state_nxt = WR;
          else                                      state_nxt = RD;
        end
      end
      RD:      state_nxt = we_q ? WR : DONE;
      WR:      state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_busy   = (state != IDLE);
    cpu_done   = (state == DONE);
    dmem_read  = (state == RD);
    dmem_write = (state == WR);
    dbg_state  = state;
  end

  // Datapath registers: dmem_addr/dmem_wdata load only when entering RD/WR so they
  // hold otherwise; cpu_err/cpu_rdata load only when entering DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q       <= 1'b0;
      f3_q       <= 3'd0;
      lane_q     <= 2'd0;
      wdata_q    <= 16'd0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            f3_q    <= cpu_funct3;
            lane_q  <= cpu_addr[1:0];
            wdata_q <= cpu_wdata[15:0];
            if (req_err) begin
              cpu_err   <= 1'b1;
              cpu_rdata <= 32'd0;
            end else begin
              dmem_addr <= {cpu_addr[31:2], 2'b00};
              if (cpu_we && cpu_funct3 == 3'b010) dmem_wdata <= cpu_wdata;
            end
          end
        end
        RD: begin
          if (we_q) begin
            dmem_wdata <= store_merge(f3_q, lane_q, wdata_q, dmem_rdata);
          end else begin
            cpu_err   <= 1'b0;
            cpu_rdata <= load_extract(f3_q, lane_q, dmem_rdata);
          end
        end
        WR: begin
          cpu_err   <= 1'b0;
          cpu_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a driver queues expected responses and dmem writes,
// a negedge monitor pops and compares them as the DUT presents cpu_done / dmem_write.
module tb_dmem_lsu;

  localparam int EW = 73; // {err, rdata[31:0], done_cycle[31:0], n_read[3:0], n_write[3:0]}

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [2:0]  cpu_funct3 = 3'd0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic        cpu_busy, cpu_done, cpu_err;
  logic [31:0] cpu_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_write, dmem_read;
  logic [1:0]  dbg_state;

  logic [31:0]   mem [0:1023];
  logic [EW-1:0] exp_q[$];
  logic [63:0]   wr_q[$];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;
  int            done_cnt = 0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;

  dmem_lsu #(.DMEM_WORDS(1024)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_write(dmem_write),
    .dmem_read(dmem_read), .dmem_rdata(dmem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // data memory model: combinational read, posedge write
  assign dmem_rdata = mem[dmem_addr[11:2]];
  always @(posedge clock) if (dmem_write) mem[dmem_addr[11:2]] <= dmem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (dmem_read) rd_cnt++;
      if (dmem_write) begin
        wr_cnt++;
        if (wr_q.size() == 0) chk("write_unexpected", 32'd1, 32'd0);
        else begin
          logic [63:0] w;
          w = wr_q.pop_front();
          chk("write_addr", dmem_addr, w[63:32]);
          chk("write_data", dmem_wdata, w[31:0]);
        end
      end
      if (cpu_done) begin
        if (exp_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("err", {31'd0, cpu_err}, {31'd0, e[72]});
          chk("rdata", cpu_rdata, e[71:40]);
          chk("done_cycle", cyc, e[39:8]);
          chk("read_count", rd_cnt, {28'd0, e[7:4]});
          chk("write_count", wr_cnt, {28'd0, e[3:0]});
        end
        rd_cnt = 0;
        wr_cnt = 0;
        done_cnt++;
      end
    end
  end

  task automatic wait_done(input int start, input int n);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      #1;
      if (done_cnt >= start + n) break;
    end
    if (k == 20) chk("done_timeout", done_cnt, start + n);
  endtask

  // driver: one access, expected response queued at issue time
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic e_err, input logic [31:0] e_rdata,
                       input int lat, input int n_rd, input int n_wr, input logic [31:0] e_wdata);
    int start;
    @(negedge clock);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_funct3 = f3;
    cpu_addr = addr;
    cpu_wdata = wdata;
    start = done_cnt;
    exp_q.push_back({e_err, e_rdata, 32'(cyc + lat), 4'(n_rd), 4'(n_wr)});
    if (n_wr != 0) wr_q.push_back({addr[31:2], 2'b00, e_wdata});
    @(posedge clock);
    #1 cpu_req = 1'b0;
    wait_done(start, 1);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] e_rdata);
    issue(1'b0, f3, addr, 32'd0, 1'b0, e_rdata, 2, 1, 0, 32'd0);
  endtask

  task automatic reject(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    issue(we, f3, addr, 32'h5A5A5A5A, 1'b1, 32'd0, 1, 0, 0, 32'd0);
  endtask

  initial begin
    int start;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[1023] = 32'hCAFEF00D;

    repeat (2) @(negedge clock);
    chk("reset_busy", {31'd0, cpu_busy}, 32'd0);
    chk("reset_done", {31'd0, cpu_done}, 32'd0);
    chk("reset_err", {31'd0, cpu_err}, 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    chk("reset_dmem_rw", {30'd0, dmem_read, dmem_write}, 32'd0);
    chk("reset_dmem_addr", dmem_addr, 32'd0);
    chk("reset_dmem_wdata", dmem_wdata, 32'd0);
    reset_n = 1'b1;

    // stores and read-modify-write merges
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'd0, 2, 0, 1, 32'hDEADBEEF);
    issue(1'b1, 3'b000, 32'h101, 32'h000000AA, 1'b0, 32'd0, 3, 1, 1, 32'hDEADAAEF);

    // load extraction over 0xDEADAAEF
    load(3'b000, 32'h103, 32'hFFFFFFDE);
    load(3'b100, 32'h103, 32'h000000DE);
    load(3'b001, 32'h102, 32'hFFFFDEAD);
    load(3'b101, 32'h102, 32'h0000DEAD);
    load(3'b000, 32'h101, 32'hFFFFFFAA);
    load(3'b100, 32'h100, 32'h000000EF);
    load(3'b001, 32'h100, 32'hFFFFAAEF);
    load(3'b010, 32'h100, 32'hDEADAAEF);

    issue(1'b1, 3'b001, 32'h102, 32'hFFFF1234, 1'b0, 32'd0, 3, 1, 1, 32'h1234AAEF);
    issue(1'b1, 3'b000, 32'h203, 32'h00000077, 1'b0, 32'd0, 3, 1, 1, 32'h77000000);
    load(3'b010, 32'h100, 32'h1234AAEF);
    load(3'b000, 32'h203, 32'h00000077);

    // rejected accesses
    reject(1'b0, 3'b010, 32'h102);
    reject(1'b1, 3'b001, 32'h103);
    reject(1'b0, 3'b011, 32'h100);
    reject(1'b0, 3'b110, 32'h100);
    reject(1'b0, 3'b111, 32'h100);
    reject(1'b1, 3'b100, 32'h100);
    reject(1'b0, 3'b101, 32'h101);
    reject(1'b1, 3'b010, 32'h1000);
    reject(1'b0, 3'b000, 32'hFFFF0000);

    // top valid word
    load(3'b010, 32'hFFC, 32'hCAFEF00D);

    // reset in the middle of a WR cycle
    @(negedge clock);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_funct3 = 3'b010;
    cpu_addr = 32'h100;
    cpu_wdata = 32'h55555555;
    wr_q.push_back({32'h100, 32'h55555555});
    @(posedge clock);
    #1 cpu_req = 1'b0;
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("midwr_write_drop", {31'd0, dmem_write}, 32'd0);
    chk("midwr_busy_drop", {31'd0, cpu_busy}, 32'd0);
    repeat (2) @(negedge clock);
    chk("midwr_no_done", {31'd0, cpu_done}, 32'd0);
    reset_n = 1'b1;
    load(3'b010, 32'h100, 32'h1234AAEF);

    // request held through DONE: second accept only in the following IDLE cycle
    @(negedge clock);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_funct3 = 3'b010;
    cpu_addr = 32'h100;
    start = done_cnt;
    exp_q.push_back({1'b0, 32'h1234AAEF, 32'(cyc + 2), 4'd1, 4'd0});
    exp_q.push_back({1'b0, 32'h1234AAEF, 32'(cyc + 5), 4'd1, 4'd0});
    repeat (4) @(posedge clock);
    #1 cpu_req = 1'b0;
    wait_done(start, 2);

    repeat (4) @(negedge clock);
    chk("exp_queue_empty", exp_q.size(), 32'd0);
    chk("write_queue_empty", wr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
